vga_sprite_renderer: RTL and testbench

//   Pixel-generation stage directly downstream of the VGA timing controller. Consumes nextX/nextY plus

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_bounce_axis.sv | 46 ++++
 rtl/vga_sprite_renderer.sv | 145 ++++++++++++++
 tb/tb_vga_sprite_renderer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA sprite renderer slice.
package vga_pkg;

    localparam int H_DISPLAY_DEF = 800;
    localparam int V_DISPLAY_DEF = 600;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_X = 2'd1,
        MOVE_Y = 2'd2,
        DONE   = 2'd3
    } sprite_state_t;

    typedef logic [10:0] xcoord_t;
    typedef logic [9:0]  ycoord_t;

    // 12-bit half-open span test; wide enough that lo+size never wraps
    function automatic logic in_span(input logic [11:0] p, input logic [11:0] lo,
                                     input logic [11:0] size);
        return (p >= lo) && (p < (lo + size));
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// Combinational next position/direction for one bouncing axis (dir_neg=1 means moving toward 0).
module vga_bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 800,
    parameter int SIZE  = 32,
    parameter int STEP  = 2,
    parameter int W     = 11
) (
    input  logic [W-1:0] pos,
    input  logic         dir_neg,
    output logic [W-1:0] next_pos,
    output logic         next_dir_neg
);

    logic [11:0] pos_ext_s;

    assign pos_ext_s = 12'(pos);

    // A zero step pins the axis, so an edge-aligned box never toggles direction
    always_comb begin
        next_pos     = pos;
        next_dir_neg = dir_neg;
        if (STEP == 0) begin
            next_pos     = pos;
            next_dir_neg = dir_neg;
        end else if (!dir_neg) begin
            if ((pos_ext_s + 12'(SIZE) + 12'(STEP)) >= 12'(LIMIT)) begin
                next_pos     = W'(LIMIT - SIZE);
                next_dir_neg = 1'b1;
            end else begin
                next_pos     = W'(pos_ext_s + 12'(STEP));
                next_dir_neg = 1'b0;
            end
        end else begin
            if (pos_ext_s <= 12'(STEP)) begin
                next_pos     = '0;
                next_dir_neg = 1'b0;
            end else begin
                next_pos     = W'(pos_ext_s - 12'(STEP));
                next_dir_neg = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_sprite_renderer.sv
// Pixel stage after the VGA timing controller: draws a bouncing box, re-registers sync/blank with RGB.
module vga_sprite_renderer
    import vga_pkg::*;
#(
    parameter int          H_DISPLAY = H_DISPLAY_DEF,
    parameter int          V_DISPLAY = V_DISPLAY_DEF,
    parameter int          BOX_W     = 32,
    parameter int          BOX_H     = 32,
    parameter int          STEP_X    = 2,
    parameter int          STEP_Y    = 1,
    parameter logic [23:0] BOX_RGB   = 24'hFF4000,
    parameter logic [23:0] BG_RGB    = 24'h002040
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        blank_n_in,
    input  logic        sync_n_in,
    input  logic        hSync_n_in,
    input  logic        vSync_n_in,
    input  logic [10:0] nextX,
    input  logic [9:0]  nextY,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        blank_n,
    output logic        sync_n,
    output logic        hSync_n,
    output logic        vSync_n,
    output logic        FrameTick
);

    sprite_state_t state_q, state_d;
    xcoord_t       boxx_q, boxx_d, nx_pos_s;
    ycoord_t       boxy_q, boxy_d, ny_pos_s;
    logic          dirx_q, dirx_d, nx_dir_s;
    logic          diry_q, diry_d, ny_dir_s;
    logic          vs_prev_q, vs_prev_d;
    logic          frame_tick_q, frame_tick_d;
    rgb_t          rgb_q, rgb_d;
    logic          blank_n_q, sync_n_q, hsync_n_q, vsync_n_q;
    logic          frame_start_s, inside_s;

    vga_bounce_axis #(.LIMIT(H_DISPLAY), .SIZE(BOX_W), .STEP(STEP_X), .W(11)) u_axis_x (
        .pos(boxx_q), .dir_neg(dirx_q), .next_pos(nx_pos_s), .next_dir_neg(nx_dir_s)
    );

    vga_bounce_axis #(.LIMIT(V_DISPLAY), .SIZE(BOX_H), .STEP(STEP_Y), .W(10)) u_axis_y (
        .pos(boxy_q), .dir_neg(diry_q), .next_pos(ny_pos_s), .next_dir_neg(ny_dir_s)
    );

    assign frame_start_s = vs_prev_q & ~vSync_n_in;
    assign inside_s      = in_span(12'(nextX), 12'(boxx_q), 12'(BOX_W)) &&
                           in_span(12'(nextY), 12'(boxy_q), 12'(BOX_H));
    assign vs_prev_d     = vSync_n_in;

    // Pixel colour; blanking wins over the box test
    always_comb begin
        rgb_d = '0;
        if (!blank_n_in) begin
            rgb_d = '0;
        end else if (inside_s) begin
            rgb_d = rgb_t'(BOX_RGB);
        end else begin
            rgb_d = rgb_t'(BG_RGB);
        end
    end

    // Movement FSM: one axis per state, so updates land inside vertical sync
    always_comb begin
        state_d      = state_q;
        boxx_d       = boxx_q;
        boxy_d       = boxy_q;
        dirx_d       = dirx_q;
        diry_d       = diry_q;
        frame_tick_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start_s && Enable) begin
                    state_d = MOVE_X;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE_X: begin
                boxx_d  = nx_pos_s;
                dirx_d  = nx_dir_s;
                state_d = MOVE_Y;
            end
            MOVE_Y: begin
                boxy_d  = ny_pos_s;
                diry_d  = ny_dir_s;
                state_d = DONE;
            end
            DONE: begin
                frame_tick_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, position and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            boxx_q       <= xcoord_t'((H_DISPLAY - BOX_W) / 2);
            boxy_q       <= ycoord_t'((V_DISPLAY - BOX_H) / 2);
            dirx_q       <= 1'b0;
            diry_q       <= 1'b0;
            vs_prev_q    <= 1'b1;
            frame_tick_q <= 1'b0;
            rgb_q        <= '0;
            blank_n_q    <= 1'b0;
            sync_n_q     <= 1'b1;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            boxx_q       <= boxx_d;
            boxy_q       <= boxy_d;
            dirx_q       <= dirx_d;
            diry_q       <= diry_d;
            vs_prev_q    <= vs_prev_d;
            frame_tick_q <= frame_tick_d;
            rgb_q        <= rgb_d;
            blank_n_q    <= blank_n_in;
            sync_n_q     <= sync_n_in;
            hsync_n_q    <= hSync_n_in;
            vsync_n_q    <= vSync_n_in;
        end
    end

    assign Red       = rgb_q.r;
    assign Green     = rgb_q.g;
    assign Blue      = rgb_q.b;
    assign blank_n   = blank_n_q;
    assign sync_n    = sync_n_q;
    assign hSync_n   = hsync_n_q;
    assign vSync_n   = vsync_n_q;
    assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench: default-geometry renderer plus a small 40x40 instance that reaches a corner quickly.
module tb_vga_sprite_renderer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        blank_n_in = 1'b0;
    logic        sync_n_in = 1'b1;
    logic        hSync_n_in = 1'b1;
    logic        vSync_n_in = 1'b1;
    logic [10:0] nextX = 11'd0;
    logic [9:0]  nextY = 10'd0;

    logic [7:0] Red, Green, Blue, Red2, Green2, Blue2;
    logic       blank_n, sync_n, hSync_n, vSync_n, FrameTick;
    logic       blank_n2, sync_n2, hSync_n2, vSync_n2, FrameTick2;

    int total = 0;
    int bad = 0;
    int ticks1 = 0;
    int ticks2 = 0;

    localparam logic [23:0] BOXC = 24'hFF4000;
    localparam logic [23:0] BGC  = 24'h002040;

    always #5 Clock = ~Clock;

    vga_sprite_renderer dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .blank_n_in(blank_n_in),
        .sync_n_in(sync_n_in), .hSync_n_in(hSync_n_in), .vSync_n_in(vSync_n_in),
        .nextX(nextX), .nextY(nextY), .Red(Red), .Green(Green), .Blue(Blue),
        .blank_n(blank_n), .sync_n(sync_n), .hSync_n(hSync_n), .vSync_n(vSync_n),
        .FrameTick(FrameTick)
    );

    vga_sprite_renderer #(.H_DISPLAY(40), .V_DISPLAY(40), .BOX_W(8), .BOX_H(8),
                          .STEP_X(2), .STEP_Y(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .blank_n_in(blank_n_in),
        .sync_n_in(sync_n_in), .hSync_n_in(hSync_n_in), .vSync_n_in(vSync_n_in),
        .nextX(nextX), .nextY(nextY), .Red(Red2), .Green(Green2), .Blue(Blue2),
        .blank_n(blank_n2), .sync_n(sync_n2), .hSync_n(hSync_n2), .vSync_n(vSync_n2),
        .FrameTick(FrameTick2)
    );

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic pix(input int x, input int y, output logic [23:0] c1, output logic [23:0] c2);
        nextX = 11'(x);
        nextY = 10'(y);
        blank_n_in = 1'b1;
        cyc();
        c1 = {Red, Green, Blue};
        c2 = {Red2, Green2, Blue2};
    endtask

    task automatic run_frame();
        blank_n_in = 1'b0;
        vSync_n_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (FrameTick)  ticks1++;
            if (FrameTick2) ticks2++;
        end
        vSync_n_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            if (FrameTick)  ticks1++;
            if (FrameTick2) ticks2++;
        end
    endtask

    task automatic test_reset();
        logic [23:0] c1, c2;
        nextX = 11'd384; nextY = 10'd284; blank_n_in = 1'b1;
        sync_n_in = 1'b0; hSync_n_in = 1'b0; vSync_n_in = 1'b0;
        cyc();
        #2 Reset = 1'b1;
        #1;
        if ({Red, Green, Blue, blank_n, sync_n, hSync_n, vSync_n, FrameTick} !== {24'h0, 5'b01110}) begin
            bad++;
            $display("FAIL reset_async: got rgb=%h b/s/h/v/t=%b%b%b%b%b want rgb=000000 b/s/h/v/t=01110",
                     {Red, Green, Blue}, blank_n, sync_n, hSync_n, vSync_n, FrameTick);
        end
        total++;
        cyc();
        if ({Red, Green, Blue, blank_n, sync_n, hSync_n, vSync_n} !== {24'h0, 4'b0111}) begin
            bad++;
            $display("FAIL reset_edge: got rgb=%h b/s/h/v=%b%b%b%b want 000000 0111",
                     {Red, Green, Blue}, blank_n, sync_n, hSync_n, vSync_n);
        end
        total++;
        sync_n_in = 1'b1; hSync_n_in = 1'b1; vSync_n_in = 1'b1;
        #2 Reset = 1'b0;
        pix(384, 284, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL reset_box_origin: got %h want %h", c1, BOXC); end
        total++;
        pix(383, 284, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL reset_box_left: got %h want %h", c1, BGC); end
        total++;
        pix(384, 283, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL reset_box_top: got %h want %h", c1, BGC); end
        total++;
        pix(16, 16, c1, c2);
        if (c2 !== BOXC) begin bad++; $display("FAIL reset_small_origin: got %h want %h", c2, BOXC); end
        total++;
    endtask

    task automatic test_pixel();
        logic [23:0] c1, c2;
        pix(384, 284, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL pix_inside: got %h want %h", c1, BOXC); end
        total++;
        pix(416, 284, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL pix_right_edge: got %h want %h", c1, BGC); end
        total++;
        pix(415, 315, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL pix_last_inside: got %h want %h", c1, BOXC); end
        total++;
        pix(384, 316, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL pix_bottom_edge: got %h want %h", c1, BGC); end
        total++;
        nextX = 11'd384; nextY = 10'd284; blank_n_in = 1'b0;
        cyc();
        if ({Red, Green, Blue} !== 24'h000000) begin
            bad++; $display("FAIL pix_blank: got %h want 000000", {Red, Green, Blue});
        end
        total++;
        if (blank_n !== 1'b0) begin bad++; $display("FAIL pix_blank_out: got %b want 0", blank_n); end
        total++;
    endtask

    task automatic test_frame_tick();
        logic [23:0] c1, c2;
        int first = 0;
        int highs = 0;
        Enable = 1'b1;
        blank_n_in = 1'b0;
        vSync_n_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (FrameTick) begin
                highs++;
                if (first == 0) first = k;
            end
        end
        vSync_n_in = 1'b1;
        cyc();
        if (first !== 4) begin bad++; $display("FAIL tick_latency: got %0d want 4", first); end
        total++;
        if (highs !== 1) begin bad++; $display("FAIL tick_width: got %0d want 1", highs); end
        total++;
        pix(386, 285, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL move_origin: got %h want %h", c1, BOXC); end
        total++;
        pix(385, 285, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL move_left: got %h want %h", c1, BGC); end
        total++;
        pix(386, 284, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL move_top: got %h want %h", c1, BGC); end
        total++;
        pix(417, 316, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL move_far_corner: got %h want %h", c1, BOXC); end
        total++;
    endtask

    // Small instance: frames 1..23 take it to (2,2) heading down, frame 24 clamps both axes
    task automatic test_corner();
        logic [23:0] c1, c2;
        ticks1 = 0;
        for (int f = 2; f <= 23; f++) run_frame();
        pix(2, 2, c1, c2);
        if (c2 !== BOXC) begin bad++; $display("FAIL corner_pre: got %h want %h", c2, BOXC); end
        total++;
        pix(1, 2, c1, c2);
        if (c2 !== BGC) begin bad++; $display("FAIL corner_pre_left: got %h want %h", c2, BGC); end
        total++;
        run_frame();
        pix(0, 0, c1, c2);
        if (c2 !== BOXC) begin bad++; $display("FAIL corner_zero: got %h want %h", c2, BOXC); end
        total++;
        pix(8, 0, c1, c2);
        if (c2 !== BGC) begin bad++; $display("FAIL corner_zero_right: got %h want %h", c2, BGC); end
        total++;
        pix(0, 8, c1, c2);
        if (c2 !== BGC) begin bad++; $display("FAIL corner_zero_bottom: got %h want %h", c2, BGC); end
        total++;
        run_frame();
        pix(2, 2, c1, c2);
        if (c2 !== BOXC) begin bad++; $display("FAIL corner_flip: got %h want %h", c2, BOXC); end
        total++;
        pix(1, 1, c1, c2);
        if (c2 !== BGC) begin bad++; $display("FAIL corner_flip_diag: got %h want %h", c2, BGC); end
        total++;
        pix(434, 309, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL big_after_25: got %h want %h", c1, BOXC); end
        total++;
        pix(433, 309, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL big_after_25_left: got %h want %h", c1, BGC); end
        total++;
        if (ticks1 !== 24) begin bad++; $display("FAIL tick_count: got %0d want 24", ticks1); end
        total++;
    endtask

    // Large instance: x=384+2n reaches 766 at frame 191, clamps to 768 at 192, returns to 766 at 193
    task automatic test_bounce();
        logic [23:0] c1, c2;
        for (int f = 26; f <= 191; f++) run_frame();
        pix(766, 475, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL bounce_766: got %h want %h", c1, BOXC); end
        total++;
        pix(798, 475, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL bounce_766_right: got %h want %h", c1, BGC); end
        total++;
        run_frame();
        pix(768, 476, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL bounce_768: got %h want %h", c1, BOXC); end
        total++;
        pix(767, 476, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL bounce_768_left: got %h want %h", c1, BGC); end
        total++;
        pix(799, 507, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL bounce_768_edge: got %h want %h", c1, BOXC); end
        total++;
        run_frame();
        pix(766, 477, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL bounce_back: got %h want %h", c1, BOXC); end
        total++;
        pix(798, 477, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL bounce_back_right: got %h want %h", c1, BGC); end
        total++;
    endtask

    task automatic test_disabled();
        logic [23:0] c1, c2;
        logic        exp_b, exp_s, exp_h, exp_v;
        int          tick_seen = 0;
        int          sync_bad = 0;
        Enable = 1'b0;
        for (int i = 0; i < 30; i++) begin
            exp_b = 1'($urandom_range(0, 1));
            exp_s = 1'($urandom_range(0, 1));
            exp_h = 1'($urandom_range(0, 1));
            exp_v = ((i % 10) < 5) ? 1'b0 : 1'b1;
            blank_n_in = exp_b; sync_n_in = exp_s; hSync_n_in = exp_h; vSync_n_in = exp_v;
            cyc();
            if ({blank_n, sync_n, hSync_n, vSync_n} !== {exp_b, exp_s, exp_h, exp_v}) begin
                sync_bad++;
                $display("FAIL sync_delay[%0d]: got %b%b%b%b want %b%b%b%b", i,
                         blank_n, sync_n, hSync_n, vSync_n, exp_b, exp_s, exp_h, exp_v);
            end
            if (FrameTick || FrameTick2) tick_seen++;
        end
        bad += sync_bad;
        total += 30;
        sync_n_in = 1'b1; hSync_n_in = 1'b1; vSync_n_in = 1'b1;
        if (tick_seen !== 0) begin bad++; $display("FAIL disabled_tick: got %0d want 0", tick_seen); end
        total++;
        pix(766, 477, c1, c2);
        if (c1 !== BOXC) begin bad++; $display("FAIL frozen_pos: got %h want %h", c1, BOXC); end
        total++;
        pix(765, 477, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL frozen_left: got %h want %h", c1, BGC); end
        total++;
        pix(766, 476, c1, c2);
        if (c1 !== BGC) begin bad++; $display("FAIL frozen_top: got %h want %h", c1, BGC); end
        total++;
    endtask

    initial begin
        cyc();
        cyc();
        test_reset();
        test_pixel();
        test_frame_tick();
        test_corner();
        test_bounce();
        test_disabled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
